// File: rtl/moon_dash_ctrl.sv
// Moon boss sequencer: aim delay, lock onto the player, straight-line dash to the border, recover.
// Holds the moon centre in signed Q.10 and runs a speed-scalable tick generator.
module moon_dash_ctrl #(
  parameter int unsigned MAX_X          = 384,
  parameter int unsigned MAX_Y          = 448,
  parameter int unsigned TIME_MAX       = 4000,
  parameter int unsigned AIM_TICKS      = 2000,
  parameter int unsigned RECOVER_TICKS  = 500,
  parameter int unsigned STEP_SHIFT     = 6,
  parameter int unsigned DASH_MAX_TICKS = 1023,
  parameter int unsigned START_X        = 192,
  parameter int unsigned START_Y        = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [25:0] speed_offset,
  input  logic [9:0]  player_x,
  input  logic [9:0]  player_y,
  output logic [9:0]  moon_x,
  output logic [9:0]  moon_y,
  output logic        aiming,
  output logic        dashing,
  output logic        dash_done,
  output logic [7:0]  dash_count
);

  localparam int unsigned CNT_W  = 26;
  localparam int unsigned PH_W   = 11;
  localparam int unsigned FRAC_W = 10;
  localparam int unsigned POS_W  = 21;
  localparam int unsigned VEL_W  = 22;
  localparam int unsigned SUM_W  = 23;

  localparam logic signed [POS_W-1:0] START_PX = POS_W'(START_X << FRAC_W);
  localparam logic signed [POS_W-1:0] START_PY = POS_W'(START_Y << FRAC_W);
  localparam logic signed [SUM_W-1:0] LIM_X    = SUM_W'(MAX_X << FRAC_W);
  localparam logic signed [SUM_W-1:0] LIM_Y    = SUM_W'(MAX_Y << FRAC_W);
  localparam logic signed [VEL_W-1:0] ONE_PX   = VEL_W'(1 << FRAC_W);

  typedef enum logic [2:0] {
    S_IDLE, S_AIM, S_LATCH, S_DASH, S_RECOVER
  } state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         tick_cnt_q, tick_cnt_d;
  logic [PH_W-1:0]          phase_q, phase_d;
  logic signed [POS_W-1:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic signed [VEL_W-1:0]  vel_x_q, vel_x_d, vel_y_q, vel_y_d;
  logic                     aiming_q, aiming_d;
  logic                     dashing_q, dashing_d;
  logic                     dash_done_q, dash_done_d;
  logic [7:0]               dash_count_q, dash_count_d;

  logic [CNT_W-1:0]         period_c;
  logic                     tick_c;
  logic signed [10:0]       dx_c, dy_c;
  logic signed [VEL_W-1:0]  dx_ext_c, dy_ext_c, vel_lx_c, vel_ly_c;
  logic signed [SUM_W-1:0]  sum_x_c, sum_y_c;
  logic signed [POS_W-1:0]  new_x_c, new_y_c;
  logic                     hit_c;

  // Tick generator; >= keeps it sane if the period shrinks below the current count
  always_comb begin
    period_c   = (speed_offset < CNT_W'(TIME_MAX)) ? (CNT_W'(TIME_MAX) - speed_offset) : '0;
    tick_c     = run && (tick_cnt_q >= period_c);
    tick_cnt_d = tick_cnt_q;
    if (run) tick_cnt_d = tick_c ? '0 : (tick_cnt_q + CNT_W'(1));
  end

  // Lock-on velocity and clamped next position
  always_comb begin
    dx_c     = $signed({1'b0, player_x}) - $signed({1'b0, pos_x_q[19:10]});
    dy_c     = $signed({1'b0, player_y}) - $signed({1'b0, pos_y_q[19:10]});
    dx_ext_c = {{(VEL_W-11){dx_c[10]}}, dx_c};
    dy_ext_c = {{(VEL_W-11){dy_c[10]}}, dy_c};
    vel_lx_c = (dx_ext_c <<< FRAC_W) >>> STEP_SHIFT;
    vel_ly_c = (dy_ext_c <<< FRAC_W) >>> STEP_SHIFT;

    sum_x_c  = $signed({{(SUM_W-POS_W){pos_x_q[POS_W-1]}}, pos_x_q})
             + $signed({{(SUM_W-VEL_W){vel_x_q[VEL_W-1]}}, vel_x_q});
    sum_y_c  = $signed({{(SUM_W-POS_W){pos_y_q[POS_W-1]}}, pos_y_q})
             + $signed({{(SUM_W-VEL_W){vel_y_q[VEL_W-1]}}, vel_y_q});
    hit_c    = 1'b0;
    new_x_c  = sum_x_c[POS_W-1:0];
    new_y_c  = sum_y_c[POS_W-1:0];
    if (sum_x_c < 0) begin
      new_x_c = '0;
      hit_c   = 1'b1;
    end else if (sum_x_c > LIM_X) begin
      new_x_c = LIM_X[POS_W-1:0];
      hit_c   = 1'b1;
    end
    if (sum_y_c < 0) begin
      new_y_c = '0;
      hit_c   = 1'b1;
    end else if (sum_y_c > LIM_Y) begin
      new_y_c = LIM_Y[POS_W-1:0];
      hit_c   = 1'b1;
    end
  end

  // Next-state and registered outputs
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    vel_x_d      = vel_x_q;
    vel_y_d      = vel_y_q;
    dash_done_d  = 1'b0;
    dash_count_d = dash_count_q;
    if (run) begin
      case (state_q)
        S_IDLE: begin
          state_d = S_AIM;
          phase_d = '0;
        end
        S_AIM: if (tick_c) begin
          if (phase_q == PH_W'(AIM_TICKS - 1)) begin
            state_d = S_LATCH;
            phase_d = '0;
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
        S_LATCH: begin
          vel_x_d = vel_lx_c;
          vel_y_d = vel_ly_c;
          if (vel_lx_c == '0 && vel_ly_c == '0) vel_y_d = ONE_PX;
          state_d = S_DASH;
          phase_d = '0;
        end
        S_DASH: if (tick_c) begin
          pos_x_d = new_x_c;
          pos_y_d = new_y_c;
          if (hit_c || phase_q == PH_W'(DASH_MAX_TICKS - 1)) begin
            state_d      = S_RECOVER;
            phase_d      = '0;
            dash_done_d  = 1'b1;
            dash_count_d = dash_count_q + 8'd1;
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
        S_RECOVER: if (tick_c) begin
          if (phase_q == PH_W'(RECOVER_TICKS - 1)) begin
            state_d = S_AIM;
            phase_d = '0;
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    aiming_d  = (state_d == S_AIM);
    dashing_d = (state_d == S_DASH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tick_cnt_q   <= '0;
      phase_q      <= '0;
      pos_x_q      <= START_PX;
      pos_y_q      <= START_PY;
      vel_x_q      <= '0;
      vel_y_q      <= '0;
      aiming_q     <= 1'b0;
      dashing_q    <= 1'b0;
      dash_done_q  <= 1'b0;
      dash_count_q <= '0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      phase_q      <= phase_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      vel_x_q      <= vel_x_d;
      vel_y_q      <= vel_y_d;
      aiming_q     <= aiming_d;
      dashing_q    <= dashing_d;
      dash_done_q  <= dash_done_d;
      dash_count_q <= dash_count_d;
    end
  end

  assign moon_x     = pos_x_q[19:10];
  assign moon_y     = pos_y_q[19:10];
  assign aiming     = aiming_q;
  assign dashing    = dashing_q;
  assign dash_done  = dash_done_q;
  assign dash_count = dash_count_q;

endmodule

// File: tb/tb_moon_dash_ctrl.sv
// Bench for moon_dash_ctrl: table of dash scenarios with a position scoreboard, plus pause/reset sequences.
module tb_moon_dash_ctrl;

  logic        clk = 1'b0;
  logic        reset, run;
  logic [25:0] speed_offset;
  logic [9:0]  player_x, player_y, moon_x, moon_y;
  logic        aiming, dashing, dash_done;
  logic [7:0]  dash_count;

  int n_cmp = 0;
  int n_bad = 0;

  moon_dash_ctrl #(.TIME_MAX(4), .AIM_TICKS(3), .RECOVER_TICKS(2)) dut (
    .clk(clk), .reset(reset), .run(run), .speed_offset(speed_offset),
    .player_x(player_x), .player_y(player_y), .moon_x(moon_x), .moon_y(moon_y),
    .aiming(aiming), .dashing(dashing), .dash_done(dash_done), .dash_count(dash_count)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; } pos_t;
  typedef struct { int so; int per; int px; int py; int n; int fx; int fy; } row_t;

  pos_t       exp_q[$];
  bit         mon_en = 1'b0;
  logic [9:0] prev_x = 10'd192;
  logic [9:0] prev_y = 10'd100;
  row_t       rows[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       return aiming;
      1:       return dashing;
      default: return dash_done;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int limit, output int cycles);
    cycles = 0;
    while (!sel(which) && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // Expected integer positions of one dash from the start point, only where they change
  task automatic build_exp(input int px, input int py);
    int x = 192 * 1024;
    int y = 100 * 1024;
    int vx = (px - 192) * 16;
    int vy = (py - 100) * 16;
    int nx, ny;
    bit hit;
    exp_q.delete();
    if (vx == 0 && vy == 0) vy = 1024;
    for (int t = 0; t < 1023; t++) begin
      nx = x + vx;
      ny = y + vy;
      hit = 1'b0;
      if (nx < 0) begin nx = 0; hit = 1'b1; end
      else if (nx > 384 * 1024) begin nx = 384 * 1024; hit = 1'b1; end
      if (ny < 0) begin ny = 0; hit = 1'b1; end
      else if (ny > 448 * 1024) begin ny = 448 * 1024; hit = 1'b1; end
      if ((nx >>> 10) != (x >>> 10) || (ny >>> 10) != (y >>> 10))
        exp_q.push_back('{nx >>> 10, ny >>> 10});
      x = nx;
      y = ny;
      if (hit) break;
    end
  endtask

  // Scoreboard: every change of the moon position pops the next expected position
  initial forever begin
    @(negedge clk);
    if (mon_en && (moon_x != prev_x || moon_y != prev_y)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_move: got (%0d,%0d) expected no move", moon_x, moon_y);
      end else begin
        pos_t e;
        e = exp_q.pop_front();
        check("move_x", 32'(moon_x), 32'(e.x));
        check("move_y", 32'(moon_y), 32'(e.y));
      end
    end
    prev_x = moon_x;
    prev_y = moon_y;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int c;
    int per;
    rows[0] = '{0,    4, 192, 356,  88, 192, 448};
    rows[1] = '{0,    4, 100, 100, 134,   0, 100};
    rows[2] = '{0,    4, 192, 100, 349, 192, 448};
    rows[3] = '{5000, 0, 192, 356,  88, 192, 448};
    rows[4] = '{4,    0, 192, 356,  88, 192, 448};
    rows[5] = '{2,    2, 192, 356,  88, 192, 448};

    reset = 1'b1;
    run = 1'b1;
    speed_offset = '0;
    player_x = 10'd192;
    player_y = 10'd356;

    for (int i = 0; i < 6; i++) begin
      per = rows[i].per;
      mon_en = 1'b0;
      speed_offset = 26'(rows[i].so);
      player_x = 10'(rows[i].px);
      player_y = 10'(rows[i].py);
      reset = 1'b1;
      run = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_moon_x", 32'(moon_x), 32'd192);
      check("rst_moon_y", 32'(moon_y), 32'd100);
      check("rst_aiming", 32'(aiming), 32'd0);
      check("rst_dashing", 32'(dashing), 32'd0);
      check("rst_dash_done", 32'(dash_done), 32'd0);
      check("rst_dash_count", 32'(dash_count), 32'd0);

      build_exp(rows[i].px, rows[i].py);
      prev_x = 10'd192;
      prev_y = 10'd100;
      mon_en = 1'b1;
      reset = 1'b0;

      wait_sig(1, 3000, c);
      check("aim_latency", 32'(c), 32'((per == 0) ? 5 : 3 * per + 4));
      player_x = 10'($urandom_range(0, 383));
      player_y = 10'($urandom_range(0, 447));
      wait_sig(2, 6000, c);
      check("dash_length", 32'(c), 32'((per == 0) ? rows[i].n : per + (per + 1) * (rows[i].n - 1)));
      check("final_x", 32'(moon_x), 32'(rows[i].fx));
      check("final_y", 32'(moon_y), 32'(rows[i].fy));
      check("dash_count", 32'(dash_count), 32'd1);
      check("moves_left", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      check("dash_done_pulse", 32'(dash_done), 32'd0);
      wait_sig(0, 3000, c);
      check("recover_len", 32'(c + 1), 32'(2 * (per + 1)));
      wait_sig(1, 3000, c);
      mon_en = 1'b0;
      check("aim_len", 32'(c), 32'(3 * (per + 1) + 1));
    end

    // Pause mid-dash, resume exactly, then reset mid-dash
    speed_offset = '0;
    player_x = 10'd192;
    player_y = 10'd356;
    reset = 1'b1;
    run = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_sig(1, 3000, c);
    wait_sig(2, 3000, c);
    wait_sig(1, 3000, c);
    check("second_dash_seen", 32'(dashing), 32'd1);
    repeat (20) @(negedge clk);
    check("pre_pause_y", 32'(moon_y), 32'((448 * 1024 - 1472 * 4) >>> 10));
    run = 1'b0;
    repeat (50) @(negedge clk);
    check("pause_x", 32'(moon_x), 32'd192);
    check("pause_y", 32'(moon_y), 32'd442);
    check("pause_dashing", 32'(dashing), 32'd1);
    check("pause_aiming", 32'(aiming), 32'd0);
    check("pause_dash_done", 32'(dash_done), 32'd0);
    check("pause_count", 32'(dash_count), 32'd1);
    run = 1'b1;
    repeat (3) @(negedge clk);
    check("resume_hold_y", 32'(moon_y), 32'd442);
    @(negedge clk);
    check("resume_tick_y", 32'(moon_y), 32'((448 * 1024 - 1472 * 5) >>> 10));
    reset = 1'b1;
    @(negedge clk);
    check("abort_x", 32'(moon_x), 32'd192);
    check("abort_y", 32'(moon_y), 32'd100);
    check("abort_dashing", 32'(dashing), 32'd0);
    check("abort_aiming", 32'(aiming), 32'd0);
    check("abort_count", 32'(dash_count), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_to_aim", 32'(aiming), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
